// File: rtl/snake_game_ctrl_if.sv
// rtl/snake_game_ctrl_if.sv - signal bundle between snake control and its environment
//
// Purpose: groups the button/datapath inputs and the game-state/direction/tick
//          outputs of snake_game_ctrl.
// Modports:
//   slave  - the controller: consumes Start, Btn*, Collision, Length;
//            drives q_*, In_Dirn, SCEN, Speed_Clk, Move_Count.
//   master - the environment (buttons + datapath): the mirror image.
interface snake_game_ctrl_if;
  logic        Start;
  logic        BtnU;
  logic        BtnD;
  logic        BtnL;
  logic        BtnR;
  logic        Collision;
  logic [7:0]  Length;
  logic        q_I;
  logic        q_Run;
  logic        q_Win;
  logic        q_Lose;
  logic [1:0]  In_Dirn;
  logic        SCEN;
  logic        Speed_Clk;
  logic [15:0] Move_Count;

  modport slave (
    input  Start, BtnU, BtnD, BtnL, BtnR, Collision, Length,
    output q_I, q_Run, q_Win, q_Lose, In_Dirn, SCEN, Speed_Clk, Move_Count
  );

  modport master (
    output Start, BtnU, BtnD, BtnL, BtnR, Collision, Length,
    input  q_I, q_Run, q_Win, q_Lose, In_Dirn, SCEN, Speed_Clk, Move_Count
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game state machine, direction filter and move tick
//
// Purpose: owns the INI/RUN/WIN/LOSE game FSM, filters button pulses into a
//          legal direction code with a one-cycle SCEN strobe, and produces the
//          Speed_Clk move enable whose period shrinks as the snake grows.
// Ports:
//   Clk   - system clock
//   Reset - synchronous, active-high reset
//   bus   - snake_game_ctrl_if.slave: Start, BtnU/D/L/R, Collision, Length in;
//           q_I/q_Run/q_Win/q_Lose, In_Dirn, SCEN, Speed_Clk, Move_Count out
module snake_game_ctrl #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned SPEED_STEP = 1000000,
  parameter int unsigned MIN_DIV    = 5000000,
  parameter int unsigned START_LEN  = 3,
  parameter int unsigned WIN_LENGTH = 20,
  parameter logic [1:0]  START_DIRN = 2'b00
) (
  input logic              Clk,
  input logic              Reset,
  snake_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_INI, S_RUN, S_WIN, S_LOSE} state_t;

  state_t      r_state;
  logic [3:0]  r_onehot;      // {I, Run, Win, Lose}
  logic [1:0]  r_dirn;        // pending direction presented on In_Dirn
  logic [1:0]  r_commit;      // direction the snake actually moved with
  logic        r_scen;
  logic        r_speed_clk;
  logic [31:0] r_cnt;
  logic [31:0] r_period;
  logic [15:0] r_move_count;

  logic [31:0] w_len32;
  logic [31:0] w_len_excess;
  logic [63:0] w_dec;
  logic [31:0] w_next_period;
  logic        w_win;
  logic        w_tick_hit;
  logic        w_press;
  logic [1:0]  w_press_dirn;
  logic        w_accept;

  assign w_len32    = {24'd0, bus.Length};
  assign w_win      = (w_len32 >= WIN_LENGTH);
  assign w_tick_hit = (r_cnt == r_period - 32'd1);

  // Lengths at or below the start length give no speed-up, so the
  // subtraction can never wrap.
  assign w_len_excess = (w_len32 > START_LEN) ? (w_len32 - START_LEN) : 32'd0;
  assign w_dec        = {32'd0, w_len_excess} * {32'd0, SPEED_STEP};

  always_comb begin
    w_next_period = MIN_DIV;
    if (w_dec < {32'd0, TICK_DIV}) begin
      if ((TICK_DIV - w_dec[31:0]) > MIN_DIV) begin
        w_next_period = TICK_DIV - w_dec[31:0];
      end
    end
  end

  // Fixed priority U > D > L > R; the code order matches In_Dirn encoding.
  always_comb begin
    w_press      = 1'b1;
    w_press_dirn = 2'b00;
    if (bus.BtnU)      w_press_dirn = 2'b00;
    else if (bus.BtnD) w_press_dirn = 2'b01;
    else if (bus.BtnL) w_press_dirn = 2'b10;
    else if (bus.BtnR) w_press_dirn = 2'b11;
    else               w_press      = 1'b0;
  end

  // Reverse of a code is the code with bit 0 flipped (UP<->DOWN, LEFT<->RIGHT).
  // The check is against the committed direction, so a turn can be revised
  // freely between ticks without ever folding the snake onto itself.
  assign w_accept = (r_state == S_RUN) && w_press &&
                    (w_press_dirn != (r_commit ^ 2'b01)) &&
                    (w_press_dirn != r_dirn);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_INI;
      r_onehot     <= 4'b1000;
      r_dirn       <= START_DIRN;
      r_commit     <= START_DIRN;
      r_scen       <= 1'b0;
      r_speed_clk  <= 1'b0;
      r_cnt        <= 32'd0;
      r_period     <= TICK_DIV;
      r_move_count <= 16'd0;
    end else begin
      r_scen      <= 1'b0;
      r_speed_clk <= 1'b0;
      // Commit in the cycle the move tick is visible, i.e. the direction the
      // datapath moves with; a press in this same cycle still sees the old value.
      if (r_speed_clk) r_commit <= r_dirn;
      if (w_accept) begin
        r_dirn <= w_press_dirn;
        r_scen <= 1'b1;
      end
      case (r_state)
        S_INI: begin
          if (bus.Start) begin
            r_state      <= S_RUN;
            r_onehot     <= 4'b0100;
            r_cnt        <= 32'd0;
            r_period     <= TICK_DIV;
            r_move_count <= 16'd0;
            r_commit     <= START_DIRN;
            r_dirn       <= START_DIRN;
          end
        end
        S_RUN: begin
          // Leaving RUN suppresses the tick so Speed_Clk is never seen
          // outside RUN.
          if (bus.Collision) begin
            r_state  <= S_LOSE;
            r_onehot <= 4'b0001;
          end else if (w_win) begin
            r_state  <= S_WIN;
            r_onehot <= 4'b0010;
          end else if (w_tick_hit) begin
            r_cnt        <= 32'd0;
            r_speed_clk  <= 1'b1;
            r_period     <= w_next_period;
            r_move_count <= (r_move_count == 16'hFFFF) ? r_move_count
                                                       : r_move_count + 16'd1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          if (bus.Start) begin
            r_state  <= S_INI;
            r_onehot <= 4'b1000;
          end
        end
      endcase
    end
  end

  assign bus.q_I        = r_onehot[3];
  assign bus.q_Run      = r_onehot[2];
  assign bus.q_Win      = r_onehot[1];
  assign bus.q_Lose     = r_onehot[0];
  assign bus.In_Dirn    = r_dirn;
  assign bus.SCEN       = r_scen;
  assign bus.Speed_Clk  = r_speed_clk;
  assign bus.Move_Count = r_move_count;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - self-checking bench for snake_game_ctrl
module tb_snake_game_ctrl;
  localparam int TICK = 10;
  localparam int STEP = 2;
  localparam int MIN  = 4;
  localparam int SLEN = 3;
  localparam int WLEN = 20;

  localparam int G_INI  = 0;
  localparam int G_RUN  = 1;
  localparam int G_WIN  = 2;
  localparam int G_LOSE = 3;

  // Button vector order: {U, D, L, R}
  localparam logic [3:0] B_U = 4'b1000;
  localparam logic [3:0] B_D = 4'b0100;
  localparam logic [3:0] B_L = 4'b0010;
  localparam logic [3:0] B_R = 4'b0001;
  localparam logic [3:0] B_N = 4'b0000;

  logic Clk = 1'b0;
  logic Reset;

  snake_game_ctrl_if u_if ();

  snake_game_ctrl #(
    .TICK_DIV  (TICK),
    .SPEED_STEP(STEP),
    .MIN_DIV   (MIN),
    .START_LEN (SLEN),
    .WIN_LENGTH(WLEN),
    .START_DIRN(2'b00)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (u_if)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: game phase, cycles elapsed in the current move interval,
  // interval length, moves, committed and pending direction, strobes.
  int         m_gs;
  int         m_el;
  int         m_per;
  int         m_mv;
  logic [1:0] m_commit;
  logic [1:0] m_pend;
  logic       m_scen;
  logic       m_tick;

  function automatic logic [3:0] onehot(input int gs);
    case (gs)
      G_INI:   return 4'b1000;
      G_RUN:   return 4'b0100;
      G_WIN:   return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic int period_for(input int len);
    int d;
    int p;
    d = len - SLEN;
    if (d < 0) d = 0;
    p = TICK - d * STEP;
    if (p < MIN) p = MIN;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic st, input logic [3:0] b, input logic col,
                            input logic [7:0] len, input logic rst);
    int         gs_n;
    int         el_n;
    int         per_n;
    int         mv_n;
    int         pick;
    logic [1:0] commit_n;
    logic [1:0] pend_n;
    logic       scen_n;
    logic       tick_n;
    if (rst) begin
      m_gs = G_INI; m_el = 0; m_per = TICK; m_mv = 0;
      m_commit = 2'b00; m_pend = 2'b00; m_scen = 1'b0; m_tick = 1'b0;
      return;
    end
    gs_n = m_gs; el_n = m_el; per_n = m_per; mv_n = m_mv;
    commit_n = m_tick ? m_pend : m_commit;
    pend_n = m_pend; scen_n = 1'b0; tick_n = 1'b0;
    case (m_gs)
      G_INI: begin
        if (st) begin
          gs_n = G_RUN; el_n = 0; per_n = TICK; mv_n = 0;
          commit_n = 2'b00; pend_n = 2'b00;
        end
      end
      G_RUN: begin
        if (col) gs_n = G_LOSE;
        else if (int'(len) >= WLEN) gs_n = G_WIN;
        else begin
          el_n = m_el + 1;
          if (el_n == m_per) begin
            tick_n = 1'b1;
            el_n = 0;
            if (m_mv < 65535) mv_n = m_mv + 1;
            per_n = period_for(int'(len));
          end
        end
        pick = -1;
        for (int k = 0; k < 4; k++) if (pick < 0 && b[3-k]) pick = k;
        if (pick >= 0 && 2'(pick) != (m_commit ^ 2'b01) && 2'(pick) != m_pend) begin
          pend_n = 2'(pick);
          scen_n = 1'b1;
        end
      end
      default: if (st) gs_n = G_INI;
    endcase
    m_gs = gs_n; m_el = el_n; m_per = per_n; m_mv = mv_n;
    m_commit = commit_n; m_pend = pend_n; m_scen = scen_n; m_tick = tick_n;
  endtask

  task automatic cycle(input logic st, input logic [3:0] b, input logic col,
                       input logic [7:0] len, input logic rst);
    @(negedge Clk);
    Reset          = rst;
    u_if.Start     = st;
    u_if.BtnU      = b[3];
    u_if.BtnD      = b[2];
    u_if.BtnL      = b[1];
    u_if.BtnR      = b[0];
    u_if.Collision = col;
    u_if.Length    = len;
    @(posedge Clk);
    model_step(st, b, col, len, rst);
    #1;
    check("model_state", {u_if.q_I, u_if.q_Run, u_if.q_Win, u_if.q_Lose}, onehot(m_gs));
    check("model_dirn", u_if.In_Dirn, m_pend);
    check("model_scen", u_if.SCEN, m_scen);
    check("model_tick", u_if.Speed_Clk, m_tick);
    check("model_moves", u_if.Move_Count, m_mv[15:0]);
  endtask

  typedef struct {
    logic       st;
    logic [3:0] b;
    logic       col;
    logic [7:0] len;
    logic [3:0] q;
    logic [1:0] d;
    logic       scen;
    logic       tick;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic       found;
    logic [7:0] lv;
    logic [7:0] rlen;
    logic [3:0] rb;

    tbl[0]  = '{1'b1, B_N, 1'b0, 8'd3,  4'b0100, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, B_D, 1'b0, 8'd3,  4'b0100, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, B_L, 1'b0, 8'd3,  4'b0100, 2'b10, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, B_N, 1'b0, 8'd3,  4'b0100, 2'b10, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, B_R, 1'b0, 8'd3,  4'b0100, 2'b11, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, B_U, 1'b0, 8'd3,  4'b0100, 2'b00, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, B_U, 1'b0, 8'd3,  4'b0100, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, B_N, 1'b0, 8'd3,  4'b0100, 2'b00, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, B_N, 1'b1, 8'd20, 4'b0001, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, B_L, 1'b0, 8'd3,  4'b0001, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{1'b1, B_N, 1'b0, 8'd3,  4'b1000, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, B_N, 1'b0, 8'd3,  4'b1000, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{1'b1, B_N, 1'b0, 8'd3,  4'b0100, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{1'b0, B_N, 1'b0, 8'd20, 4'b0010, 2'b00, 1'b0, 1'b0};
    tbl[14] = '{1'b1, B_N, 1'b0, 8'd3,  4'b1000, 2'b00, 1'b0, 1'b0};

    Reset = 1'b1;
    u_if.Start = 1'b0; u_if.BtnU = 1'b0; u_if.BtnD = 1'b0; u_if.BtnL = 1'b0;
    u_if.BtnR = 1'b0; u_if.Collision = 1'b0; u_if.Length = 8'd3;
    cycle(1'b0, B_N, 1'b0, 8'd3, 1'b1);
    cycle(1'b0, B_N, 1'b0, 8'd3, 1'b1);
    check("reset_state", {u_if.q_I, u_if.q_Run, u_if.q_Win, u_if.q_Lose}, 4'b1000);
    check("reset_dirn", u_if.In_Dirn, 2'b00);
    check("reset_scen", u_if.SCEN, 1'b0);
    check("reset_tick", u_if.Speed_Clk, 1'b0);
    check("reset_moves", u_if.Move_Count, 16'd0);

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].st, tbl[i].b, tbl[i].col, tbl[i].len, 1'b0);
      check($sformatf("tbl%0d_state", i), {u_if.q_I, u_if.q_Run, u_if.q_Win, u_if.q_Lose}, tbl[i].q);
      check($sformatf("tbl%0d_dirn", i), u_if.In_Dirn, tbl[i].d);
      check($sformatf("tbl%0d_scen", i), u_if.SCEN, tbl[i].scen);
      check($sformatf("tbl%0d_tick", i), u_if.Speed_Clk, tbl[i].tick);
    end

    // Tick spacing: 10 at length 3, 6 after length 5, clamped to 4 at length 9.
    cycle(1'b1, B_N, 1'b0, 8'd3, 1'b0);
    check("t1_run", u_if.q_Run, 1'b1);
    for (int i = 1; i <= 60; i++) begin
      lv = (i <= 30) ? 8'd3 : (i <= 46) ? 8'd5 : 8'd9;
      cycle(1'b0, B_N, 1'b0, lv, 1'b0);
      check($sformatf("t12_tick_%0d", i), u_if.Speed_Clk, (i inside {10, 20, 30, 40, 46, 52, 56, 60}));
      if (i == 30) check("t1_moves30", u_if.Move_Count, 16'd3);
    end
    check("t2_moves60", u_if.Move_Count, 16'd8);

    // Commit LEFT, then a reversing R is rejected and U beats R.
    cycle(1'b0, B_L, 1'b0, 8'd9, 1'b0);
    check("t4_left", u_if.In_Dirn, 2'b10);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(1'b0, B_N, 1'b0, 8'd9, 1'b0);
      found = u_if.Speed_Clk;
    end
    check("t4_tick_seen", found, 1'b1);
    cycle(1'b0, B_N, 1'b0, 8'd9, 1'b0);
    cycle(1'b0, B_R, 1'b0, 8'd9, 1'b0);
    check("t4_rev_dirn", u_if.In_Dirn, 2'b10);
    check("t4_rev_scen", u_if.SCEN, 1'b0);
    cycle(1'b0, B_U | B_R, 1'b0, 8'd9, 1'b0);
    check("t4_prio_dirn", u_if.In_Dirn, 2'b00);
    check("t4_prio_scen", u_if.SCEN, 1'b1);

    // A press in the tick cycle is judged against the pre-tick commit (LEFT),
    // so DOWN is legal even though UP is about to be committed.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(1'b0, B_N, 1'b0, 8'd9, 1'b0);
      found = u_if.Speed_Clk;
    end
    check("t4b_tick_seen", found, 1'b1);
    cycle(1'b0, B_D, 1'b0, 8'd9, 1'b0);
    check("t4b_dirn", u_if.In_Dirn, 2'b01);
    check("t4b_scen", u_if.SCEN, 1'b1);

    // Collision together with winning length: LOSE, then no ticks.
    cycle(1'b0, B_N, 1'b1, 8'd20, 1'b0);
    check("t5_lose", {u_if.q_Win, u_if.q_Lose}, 2'b01);
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, B_N, 1'b0, 8'd3, 1'b0);
      check($sformatf("t5_notick_%0d", k), u_if.Speed_Clk, 1'b0);
    end
    cycle(1'b1, B_N, 1'b0, 8'd3, 1'b0);
    check("t5_ini", u_if.q_I, 1'b1);
    cycle(1'b1, B_N, 1'b0, 8'd3, 1'b0);
    check("t5_run", u_if.q_Run, 1'b1);
    check("t5_moves0", u_if.Move_Count, 16'd0);

    // Reset mid-game with a pending turn.
    for (int k = 0; k < 12; k++) cycle(1'b0, B_N, 1'b0, 8'd3, 1'b0);
    check("t6_moves_pre", u_if.Move_Count, 16'd1);
    cycle(1'b0, B_L, 1'b0, 8'd3, 1'b0);
    check("t6_pending", u_if.In_Dirn, 2'b10);
    cycle(1'b0, B_N, 1'b0, 8'd3, 1'b1);
    check("t6_state", {u_if.q_I, u_if.q_Run, u_if.q_Win, u_if.q_Lose}, 4'b1000);
    check("t6_dirn", u_if.In_Dirn, 2'b00);
    check("t6_moves", u_if.Move_Count, 16'd0);
    check("t6_tick", u_if.Speed_Clk, 1'b0);

    // Randomised play against the model.
    rlen = 8'd3;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 31) == 0) rlen = 8'($urandom_range(0, 21));
      rb = {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0};
      cycle($urandom_range(0, 15) == 0, rb, $urandom_range(0, 63) == 0, rlen,
            $urandom_range(0, 499) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
